hazard_stall_ctrl: RTL and testbench

// - Pipeline hazard controller for the 5-stage RISC core. It drives ST into the control-bubble mux in ID and gates PC / IF-ID writes.
// - Detects load-use hazards against a shadow scoreboard of in-flight loads.
// - Flushes on a taken branch and freezes the whole pipe while data memory is busy.
// - Also counts load-use bubble cycles for performance tracking.

---
 rtl/riscv_pipe_pkg.sv | 33 +++
 rtl/hazard_stall_ctrl_if.sv | 33 +++
 rtl/hazard_stall_ctrl_scoreboard.sv | 38 +++
 rtl/hazard_stall_ctrl.sv | 108 ++++++++++
 tb/tb_hazard_stall_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline types: register address, hazard FSM states, scoreboard entry, control bundle.
package riscv_pipe_pkg;

  localparam int REG_AW = 5;
  localparam int CTRL_W = 7;   // width of the ID control bus zeroed by the bubble mux

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic      vld;
    reg_addr_t rd;
  } sb_entry_t;

  typedef struct packed {
    logic st;
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic pipe_hold;
  } hz_ctrl_t;

  // A source operand collides with an in-flight load only if it is read, non-x0 and equal.
  function automatic logic rs_match(logic use_rs, reg_addr_t rs, sb_entry_t e);
    return use_rs && (rs != '0) && e.vld && (rs == e.rd);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// ID-stage hazard bus: decode fields and memory status in, pipeline enables out.
interface hazard_stall_ctrl_if #(parameter int CNT_W = 16);
  import riscv_pipe_pkg::*;

  reg_addr_t        ifid_rs1;
  reg_addr_t        ifid_rs2;
  logic             ifid_use_rs1;
  logic             ifid_use_rs2;
  reg_addr_t        id_rd;
  logic             id_mem_read;
  logic             id_reg_write;
  logic             branch_taken;
  logic             mem_busy;
  logic             st;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             pipe_hold;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2, id_rd,
           id_mem_read, id_reg_write, branch_taken, mem_busy,
    input  st, pc_write, ifid_write, ifid_flush, pipe_hold, stall_cnt
  );

  modport slave (
    input  ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2, id_rd,
           id_mem_read, id_reg_write, branch_taken, mem_busy,
    output st, pc_write, ifid_write, ifid_flush, pipe_hold, stall_cnt
  );

endinterface

// File: rtl/hazard_stall_ctrl_scoreboard.sv
// Shadow scoreboard of in-flight loads: LOAD_LAT-deep {vld, rd} shift register plus rs compares.
module load_scoreboard
  import riscv_pipe_pkg::*;
#(
  parameter int LOAD_LAT = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      shift_en,
  input  logic      cap_vld,
  input  reg_addr_t cap_rd,
  input  logic      use_rs1,
  input  logic      use_rs2,
  input  reg_addr_t rs1,
  input  reg_addr_t rs2,
  output logic      hazard
);

  sb_entry_t [LOAD_LAT-1:0] sb_q;
  logic      [LOAD_LAT-1:0] hit;

  // Advance the load history whenever the pipe moves; a held pipe freezes every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q <= '0;
    end else if (shift_en) begin
      sb_q[0] <= {cap_vld, cap_rd};
      for (int k = 1; k < LOAD_LAT; k++) sb_q[k] <= sb_q[k-1];
    end
  end

  for (genvar k = 0; k < LOAD_LAT; k++) begin : g_cmp
    assign hit[k] = rs_match(use_rs1, rs1, sb_q[k]) | rs_match(use_rs2, rs2, sb_q[k]);
  end

  assign hazard = |hit;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use / branch-flush / memory-hold controller for the 5-stage core.
module hazard_stall_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 16
) (
  input logic                clk,
  input logic                rst_n,
  hazard_stall_ctrl_if.slave bus
);

  localparam int FC_W = 2;

  hz_state_e        state_q, state_d, eff;
  logic [FC_W-1:0]  fcnt_q, fcnt_d;
  logic [CNT_W-1:0] cnt_q;
  logic             hazard, cnt_inc;
  hz_ctrl_t         ctrl;

  load_scoreboard #(.LOAD_LAT(LOAD_LAT)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (!ctrl.pipe_hold),
    .cap_vld  (!ctrl.st & bus.id_mem_read & bus.id_reg_write & (bus.id_rd != '0)),
    .cap_rd   (bus.id_rd),
    .use_rs1  (bus.ifid_use_rs1),
    .use_rs2  (bus.ifid_use_rs2),
    .rs1      (bus.ifid_rs1),
    .rs2      (bus.ifid_rs2),
    .hazard   (hazard)
  );

  // HOLD releases in the same cycle mem_busy drops, resuming a pending flush if any remains.
  always_comb begin
    eff = state_q;
    if (state_q == HOLD && !bus.mem_busy) eff = (fcnt_q != '0) ? FLUSH : RUN;
  end

  // State and flush-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Next state: memory stall dominates, a flush runs to completion, branches only seen in RUN.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (bus.mem_busy) begin
      state_d = HOLD;
    end else if (eff == FLUSH) begin
      fcnt_d  = fcnt_q - 1'b1;
      state_d = (fcnt_q == FC_W'(1)) ? RUN : FLUSH;
    end else begin
      state_d = RUN;
      if (bus.branch_taken) begin
        fcnt_d  = FC_W'(FLUSH_CYC - 1);
        state_d = (FLUSH_CYC > 1) ? FLUSH : RUN;
      end
    end
  end

  // Outputs: hold > flush/branch > load-use bubble > free run; reset forces the run values.
  always_comb begin
    ctrl.st         = 1'b0;
    ctrl.pc_write   = 1'b1;
    ctrl.ifid_write = 1'b1;
    ctrl.ifid_flush = 1'b0;
    ctrl.pipe_hold  = 1'b0;
    cnt_inc         = 1'b0;
    if (!rst_n) begin
      cnt_inc = 1'b0;
    end else if (bus.mem_busy) begin
      ctrl.pipe_hold  = 1'b1;
      ctrl.pc_write   = 1'b0;
      ctrl.ifid_write = 1'b0;
    end else if (eff == FLUSH || bus.branch_taken) begin
      ctrl.st         = 1'b1;
      ctrl.ifid_flush = 1'b1;
    end else if (hazard) begin
      ctrl.st         = 1'b1;
      ctrl.pc_write   = 1'b0;
      ctrl.ifid_write = 1'b0;
      cnt_inc         = 1'b1;
    end
  end

  // Saturating load-use bubble counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt_q <= '0;
    else if (cnt_inc && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign bus.st         = ctrl.st;
  assign bus.pc_write   = ctrl.pc_write;
  assign bus.ifid_write = ctrl.ifid_write;
  assign bus.ifid_flush = ctrl.ifid_flush;
  assign bus.pipe_hold  = ctrl.pipe_hold;
  assign bus.stall_cnt  = cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Two controller instances (LOAD_LAT=1/FLUSH_CYC=2/16-bit, LOAD_LAT=2/FLUSH_CYC=3/4-bit)
// share one stimulus stream and are checked every cycle against a history-queue model.
module tb_hazard_stall_ctrl;
  import riscv_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if #(.CNT_W(16)) b0 ();
  hazard_stall_ctrl_if #(.CNT_W(4))  b1 ();

  hazard_stall_ctrl #(.LOAD_LAT(1), .FLUSH_CYC(2), .CNT_W(16)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  hazard_stall_ctrl #(.LOAD_LAT(2), .FLUSH_CYC(3), .CNT_W(4))  dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  reg_addr_t rs1, rs2, rd;
  logic      u1, u2, mr, rw, br, mb;

  assign b0.ifid_rs1 = rs1;  assign b1.ifid_rs1 = rs1;
  assign b0.ifid_rs2 = rs2;  assign b1.ifid_rs2 = rs2;
  assign b0.ifid_use_rs1 = u1; assign b1.ifid_use_rs1 = u1;
  assign b0.ifid_use_rs2 = u2; assign b1.ifid_use_rs2 = u2;
  assign b0.id_rd = rd;      assign b1.id_rd = rd;
  assign b0.id_mem_read = mr;  assign b1.id_mem_read = mr;
  assign b0.id_reg_write = rw; assign b1.id_reg_write = rw;
  assign b0.branch_taken = br; assign b1.branch_taken = br;
  assign b0.mem_busy = mb;   assign b1.mem_busy = mb;

  // {st, pc_write, ifid_write, ifid_flush, pipe_hold}
  wire [4:0]  act0 = {b0.st, b0.pc_write, b0.ifid_write, b0.ifid_flush, b0.pipe_hold};
  wire [4:0]  act1 = {b1.st, b1.pc_write, b1.ifid_write, b1.ifid_flush, b1.pipe_hold};
  wire [15:0] sc0  = b0.stall_cnt;
  wire [15:0] sc1  = {12'd0, b1.stall_cnt};

  localparam logic [4:0] E_RUN   = 5'b01100;
  localparam logic [4:0] E_HOLD  = 5'b00001;
  localparam logic [4:0] E_FLUSH = 5'b11110;
  localparam logic [4:0] E_STALL = 5'b10000;

  localparam int LL   [2] = '{1, 2};
  localparam int FC   [2] = '{2, 3};
  localparam int CMAX [2] = '{65535, 15};

  // Model: hist[i][k] = rd of the load issued k+1 pipe advances ago (0 = no load/bubble),
  // fl = flush cycles still owed, cnt = bubbles counted.
  int hist   [2][2];
  int n_hist [2][2];
  int fl [2], n_fl [2], cnt [2], n_cnt [2];
  int tests = 0, fails = 0;
  int cyc = 0;

  always @(negedge clk) begin
    logic       hz;
    int         push;
    logic [4:0] e, a;
    logic [15:0] s;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      n_fl[i] = fl[i];
      n_cnt[i] = cnt[i];
      for (int k = 0; k < 2; k++) n_hist[i][k] = hist[i][k];
      push = -1;
      hz = 1'b0;
      for (int k = 0; k < LL[i]; k++)
        if (hist[i][k] > 0 && ((u1 && int'(rs1) == hist[i][k]) || (u2 && int'(rs2) == hist[i][k])))
          hz = 1'b1;
      if (!rst_n) e = E_RUN;
      else if (mb) e = E_HOLD;
      else if (fl[i] > 0) begin e = E_FLUSH; n_fl[i] = fl[i] - 1; push = 0; end
      else if (br) begin e = E_FLUSH; n_fl[i] = FC[i] - 1; push = 0; end
      else if (hz) begin
        e = E_STALL; push = 0;
        if (cnt[i] < CMAX[i]) n_cnt[i] = cnt[i] + 1;
      end else begin
        e = E_RUN;
        push = (mr && rw) ? int'(rd) : 0;
      end
      if (push >= 0) begin n_hist[i][1] = hist[i][0]; n_hist[i][0] = push; end
      a = (i == 0) ? act0 : act1;
      s = (i == 0) ? sc0 : sc1;
      tests++;
      if (a !== e || s !== 16'(cnt[i])) begin
        fails++;
        $display("FAIL model_cmp inst%0d cyc%0d: ctrl=%b cnt=%0d, expected ctrl=%b cnt=%0d",
                 i, cyc, a, s, e, cnt[i]);
      end
    end
  end

  // Commit the model on the active edge; async reset clears it.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        fl[i] = 0; cnt[i] = 0; hist[i][0] = 0; hist[i][1] = 0;
      end else begin
        fl[i] = n_fl[i]; cnt[i] = n_cnt[i];
        hist[i][0] = n_hist[i][0]; hist[i][1] = n_hist[i][1];
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] a, input logic [15:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, a, e);
    end
  endtask

  task automatic drive(input int r1, input int r2, input int d, input logic uu1, input logic uu2,
                       input logic m, input logic w, input logic b, input logic busy);
    rs1 = reg_addr_t'(r1); rs2 = reg_addr_t'(r2); rd = reg_addr_t'(d);
    u1 = uu1; u2 = uu2; mr = m; rw = w; br = b; mb = busy;
  endtask

  task automatic nop();                          drive(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic lw(input int d);                drive(0, 0, d, 0, 0, 1, 1, 0, 0); endtask
  task automatic add(input int a, input int b2); drive(a, b2, 6, 1, 1, 0, 1, 0, 0); endtask
  task automatic to_pos(); @(posedge clk); #1; endtask
  task automatic to_neg(); @(negedge clk); #1; endtask

  initial begin
    rst_n = 1'b0;
    nop();
    repeat (2) @(posedge clk);
    to_neg();
    chk("reset_ctrl0", 16'(act0), 16'(E_RUN));
    chk("reset_cnt0", sc0, 16'd0);
    to_pos(); rst_n = 1'b1;

    // lw x5 ; add x6,x5,x7
    lw(5); to_neg();
    to_pos(); add(5, 7); to_neg();
    chk("lu_stall0", 16'(act0), 16'(E_STALL));
    chk("lu_stall1", 16'(act1), 16'(E_STALL));
    to_pos(); to_neg();
    chk("lu_go0", 16'(act0), 16'(E_RUN));
    chk("lu_cnt0", sc0, 16'd1);
    chk("lu_2nd_bubble1", 16'(act1), 16'(E_STALL));
    to_pos(); to_neg();
    chk("lu_go1", 16'(act1), 16'(E_RUN));
    chk("lu_cnt1", sc1, 16'd2);

    // lw x0 ; add x6,x0,x1 -> no stall
    to_pos(); lw(0); to_neg();
    to_pos(); add(0, 1); to_neg();
    chk("x0_nostall0", 16'(act0), 16'(E_RUN));
    chk("x0_nostall1", 16'(act1), 16'(E_RUN));
    // lw x5 ; add x6,x1,x2 -> no stall
    to_pos(); lw(5); to_neg();
    to_pos(); add(1, 2); to_neg();
    chk("indep_nostall1", 16'(act1), 16'(E_RUN));

    // Branch concurrent with a load-use hazard: flush wins, no count
    to_pos(); lw(5); to_neg();
    to_pos(); add(5, 7); br = 1'b1; to_neg();
    chk("br_flush0", 16'(act0), 16'(E_FLUSH));
    to_pos(); br = 1'b0; to_neg();
    chk("br_flush0_c2", 16'(act0), 16'(E_FLUSH));
    to_pos(); to_neg();
    chk("br_done0", 16'(act0), 16'(E_RUN));
    chk("br_flush1_c3", 16'(act1), 16'(E_FLUSH));
    chk("br_nocnt0", sc0, 16'd1);
    to_pos(); nop(); to_neg();
    chk("br_nocnt1", sc1, 16'd2);

    // mem_busy held 3 cycles during a load-use stall
    to_pos(); lw(5); to_neg();
    to_pos(); add(5, 7); mb = 1'b1; to_neg();
    chk("hold_c1", 16'(act0), 16'(E_HOLD));
    to_pos(); to_neg();
    to_pos(); to_neg();
    chk("hold_c3", 16'(act1), 16'(E_HOLD));
    to_pos(); mb = 1'b0; to_neg();
    chk("hold_resume_stall0", 16'(act0), 16'(E_STALL));
    to_pos(); to_neg();
    chk("hold_after0", 16'(act0), 16'(E_RUN));
    to_pos(); to_neg();
    chk("hold_cnt0", sc0, 16'd2);
    chk("hold_cnt1", sc1, 16'd4);

    // Saturation of the 4-bit counter
    for (int n = 0; n < 7; n++) begin
      to_pos(); lw(5);
      to_pos(); add(5, 5);
      to_pos(); to_pos();
    end
    to_pos(); nop(); to_neg();
    chk("sat_cnt1", sc1, 16'hF);
    chk("cnt0_after_loop", sc0, 16'd9);

    // Reset asserted mid-FLUSH
    to_pos(); lw(5);
    to_pos(); br = 1'b1; mr = 1'b0;
    to_pos(); nop();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_ctrl0", 16'(act0), 16'(E_RUN));
    chk("rst_mid_ctrl1", 16'(act1), 16'(E_RUN));
    chk("rst_mid_cnt0", sc0, 16'd0);
    to_pos(); rst_n = 1'b1; add(5, 7); to_neg();
    chk("post_rst_issue1", 16'(act1), 16'(E_RUN));

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      to_pos();
      drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 9) < 4), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) < 3));
    end
    to_pos(); nop(); to_neg();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
